// File: rtl/duck_hunt_pkg.sv
// Shared types and default frame counts for the light-gun flash sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package duck_hunt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        BLACK = 3'd2,
        WHITE = 3'd3,
        COOL  = 3'd4
    } flash_state_t;

    localparam int DEF_BLACK_FRAMES    = 1;
    localparam int DEF_WHITE_FRAMES    = 1;
    localparam int DEF_COOLDOWN_FRAMES = 4;
    localparam int DEF_FRAME_CNT_W     = 4;

endpackage

// File: rtl/flash_frame_cnt.sv
// Frame counter shared by the BLACK/WHITE/COOL phases, with a clear and a terminal-count flag.
// Latency: clear/step take effect on the next edge; tc_o is combinational from the count.
// Backpressure: none; the owner decides when to clear or step.
module flash_frame_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         step_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Frame count register: clear wins over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/flash_seq.sv
// Light-gun flash sequencer: black frame(s), white-target frame(s), cooldown, then hit/miss verdict.
// Latency: flash_black rises the cycle after the first frame_start following shot_req; all outputs registered.
// Backpressure: none; shot_req while busy is discarded and flagged on req_dropped.
// Optional: FLASH_MOUSE_BYPASS_EN -- with no gun connected, a shot resolves immediately as a miss without flashing.
module flash_seq
    import duck_hunt_pkg::*;
#(
    parameter int BLACK_FRAMES    = DEF_BLACK_FRAMES,
    parameter int WHITE_FRAMES    = DEF_WHITE_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int FRAME_CNT_W     = DEF_FRAME_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic shot_req,
    input  logic gun_is_connected,
    input  logic gun_photodetector,
    output logic flash_black,
    output logic flash_white,
    output logic busy,
    output logic seq_done,
    output logic target_hit,
    output logic target_miss,
    output logic req_dropped
);

    // Terminal counts per phase; the cooldown one is unused when there is no cooldown.
    localparam logic [FRAME_CNT_W-1:0] BLACK_TC = FRAME_CNT_W'(BLACK_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] WHITE_TC = FRAME_CNT_W'(WHITE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] COOL_TC  =
        FRAME_CNT_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);

    flash_state_t state_q, state_d;
    logic dark_seen_q, dark_seen_d;
    logic white_seen_q, white_seen_d;
    logic flash_black_q, flash_white_q, busy_q;
    logic seq_done_q, seq_done_d;
    logic hit_q, hit_d;
    logic miss_q, miss_d;
    logic drop_q, drop_d;

    logic                   cnt_clr, cnt_step, cnt_tc;
    logic [FRAME_CNT_W-1:0] cnt_term;

`ifndef FLASH_MOUSE_BYPASS_EN
    // Connection state only matters for the mouse bypass.
    logic unused_gun_conn;
    assign unused_gun_conn = gun_is_connected;
`endif

    flash_frame_cnt #(
        .W (FRAME_CNT_W)
    ) u_frame_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .step_i (cnt_step),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    // Next state, light flags and one-cycle event pulses.
    always_comb begin
        state_d      = state_q;
        dark_seen_d  = dark_seen_q;
        white_seen_d = white_seen_q;
        seq_done_d   = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_step     = 1'b0;
        cnt_term     = BLACK_TC;
        drop_d       = shot_req && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (shot_req) begin
`ifdef FLASH_MOUSE_BYPASS_EN
                    if (!gun_is_connected) begin
                        seq_done_d = 1'b1;
                        miss_d     = 1'b1;
                    end else begin
                        state_d = ARM;
                    end
`else
                    state_d = ARM;
`endif
                end
            end
            ARM: begin
                // A frame_start coinciding with the request was seen in IDLE, so this waits a full frame boundary.
                if (frame_start) begin
                    state_d      = BLACK;
                    cnt_clr      = 1'b1;
                    dark_seen_d  = 1'b0;
                    white_seen_d = 1'b0;
                end
            end
            BLACK: begin
                dark_seen_d = dark_seen_q | gun_photodetector;
                cnt_term    = BLACK_TC;
                if (frame_start) begin
                    if (cnt_tc) begin
                        state_d = WHITE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            WHITE: begin
                // The last WHITE cycle still counts towards the verdict.
                white_seen_d = white_seen_q | gun_photodetector;
                cnt_term     = WHITE_TC;
                if (frame_start) begin
                    if (cnt_tc) begin
                        seq_done_d = 1'b1;
                        hit_d      = white_seen_d && !dark_seen_q;
                        miss_d     = !hit_d;
                        cnt_clr    = 1'b1;
                        state_d    = (COOLDOWN_FRAMES == 0) ? IDLE : COOL;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            COOL: begin
                cnt_term = COOL_TC;
                if (frame_start) begin
                    if (cnt_tc) begin
                        state_d = IDLE;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, light flags and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dark_seen_q   <= 1'b0;
            white_seen_q  <= 1'b0;
            flash_black_q <= 1'b0;
            flash_white_q <= 1'b0;
            busy_q        <= 1'b0;
            seq_done_q    <= 1'b0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dark_seen_q   <= dark_seen_d;
            white_seen_q  <= white_seen_d;
            flash_black_q <= (state_d == BLACK);
            flash_white_q <= (state_d == WHITE);
            busy_q        <= (state_d != IDLE);
            seq_done_q    <= seq_done_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            drop_q        <= drop_d;
        end
    end

    assign flash_black = flash_black_q;
    assign flash_white = flash_white_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign target_hit  = hit_q;
    assign target_miss = miss_q;
    assign req_dropped = drop_q;

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: frame_start every 100 cycles, table of full sequences plus reset/bypass cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_flash_seq;

    logic clk = 1'b0;
    logic rst_n, frame_start, shot_req, gun_is_connected, gun_photodetector;
    logic flash_black, flash_white, busy, seq_done, target_hit, target_miss, req_dropped;

    always #5 clk = ~clk;

    flash_seq #(
        .BLACK_FRAMES    (1),
        .WHITE_FRAMES    (1),
        .COOLDOWN_FRAMES (2),
        .FRAME_CNT_W     (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_start       (frame_start),
        .shot_req          (shot_req),
        .gun_is_connected  (gun_is_connected),
        .gun_photodetector (gun_photodetector),
        .flash_black       (flash_black),
        .flash_white       (flash_white),
        .busy              (busy),
        .seq_done          (seq_done),
        .target_hit        (target_hit),
        .target_miss       (target_miss),
        .req_dropped       (req_dropped)
    );

    typedef struct {
        bit pd_b;      // light the detector during the black frame
        bit pd_w;      // light the detector during the white frame
        bit gun;       // gun_is_connected level
        bit drops;     // extra shot_req in ARM, WHITE and COOL
        int exp_hit;
        int exp_drops;
    } vec_t;

    vec_t tbl[6];

    int cyc, total, bad;
    int pd_base;
    bit pd_b, pd_w;
    int n_black, n_white, n_busy, n_done, n_hit, n_miss, n_drop, n_incoh;
    int first_black, first_white, done_cyc, last_busy;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_acc();
        n_black = 0; n_white = 0; n_busy = 0; n_done = 0;
        n_hit = 0; n_miss = 0; n_drop = 0; n_incoh = 0;
        first_black = -1; first_white = -1; done_cyc = -1; last_busy = -1;
    endtask

    // Advance one clock, log the outputs now visible for cycle cyc, then drive inputs for cycle cyc.
    task automatic step();
        int rel;
        @(posedge clk);
        #1;
        cyc++;
        if (flash_black) begin n_black++; if (first_black < 0) first_black = cyc; end
        if (flash_white) begin n_white++; if (first_white < 0) first_white = cyc; end
        if (busy) begin n_busy++; last_busy = cyc; end
        if (seq_done) begin n_done++; done_cyc = cyc; end
        if (target_hit) n_hit++;
        if (target_miss) n_miss++;
        if (req_dropped) n_drop++;
        if (((target_hit || target_miss) != seq_done) || (target_hit && target_miss)) n_incoh++;
        frame_start = ((cyc % 100) == 0);
        shot_req = 1'b0;
        gun_photodetector = 1'b0;
        if (pd_base >= 0 && cyc > pd_base) begin
            rel = cyc - pd_base - 1;
            if ((rel % 100) >= 5 && (rel % 100) <= 95) begin
                if (rel / 100 == 1 && pd_b) gun_photodetector = 1'b1;
                if (rel / 100 == 2 && pd_w) gun_photodetector = 1'b1;
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    // One full sequence: shot at base+10; black base+101..200, white base+201..300, done at base+301, idle after base+500.
    task automatic run_seq(input vec_t v);
        int base;
        base = ((cyc / 100) + 1) * 100;
        clr_acc();
        gun_is_connected = v.gun;
        pd_b = v.pd_b;
        pd_w = v.pd_w;
        pd_base = base;
        wait_until(base + 10);
        shot_req = 1'b1;
        if (v.drops) begin
            wait_until(base + 60);  shot_req = 1'b1;
            wait_until(base + 250); shot_req = 1'b1;
            wait_until(base + 450); shot_req = 1'b1;
        end
        wait_until(base + 560);
        pd_base = -1;
        chk("first_black", first_black, base + 101);
        chk("black_len", n_black, 100);
        chk("first_white", first_white, base + 201);
        chk("white_len", n_white, 100);
        chk("done_count", n_done, 1);
        chk("done_cycle", done_cyc, base + 301);
        chk("hit", n_hit, v.exp_hit);
        chk("miss", n_miss, 1 - v.exp_hit);
        chk("busy_end", last_busy, base + 500);
        chk("busy_len", n_busy, 490);
        chk("dropped", n_drop, v.exp_drops);
        chk("pulse_coherent", n_incoh, 0);
    endtask

    initial begin
        int base;
        vec_t v;
        total = 0; bad = 0; cyc = 0; pd_base = -1; pd_b = 0; pd_w = 0;
        rst_n = 1'b0; frame_start = 1'b0; shot_req = 1'b0;
        gun_is_connected = 1'b1; gun_photodetector = 1'b0;

        //              pd_b pd_w gun drops hit drops
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};   // clean hit
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};   // lamp: lit in both phases
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0};   // never lit
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};   // lit only in black
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 3};   // hit with requests dropped in ARM/WHITE/COOL
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};   // fresh request after returning to IDLE

        // Reset values held while rst_n is low.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({flash_black, flash_white, busy, seq_done, target_hit, target_miss, req_dropped}), 0);
        rst_n = 1'b1;

        // Idle frames: nothing happens.
        clr_acc();
        wait_until(250);
        chk("idle_busy", n_busy, 0);
        chk("idle_black", n_black + n_white, 0);
        chk("idle_done", n_done + n_hit + n_miss + n_drop, 0);

        for (int i = 0; i < 6; i++) run_seq(tbl[i]);

        // Reset mid-BLACK aborts at once with no seq_done.
        base = ((cyc / 100) + 1) * 100;
        clr_acc();
        wait_until(base + 10);
        shot_req = 1'b1;
        wait_until(base + 150);
        chk("pre_reset_black", int'(flash_black), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({flash_black, flash_white, busy, seq_done, target_hit, target_miss, req_dropped}), 0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_until(base + 560);
        chk("aborted_black_len", n_black, 50);
        chk("aborted_white", n_white, 0);
        chk("aborted_done", n_done + n_hit + n_miss, 0);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
        run_seq(v);

        // Shot with no gun connected.
`ifdef FLASH_MOUSE_BYPASS_EN
        base = ((cyc / 100) + 1) * 100;
        clr_acc();
        gun_is_connected = 1'b0;
        wait_until(base + 10);
        shot_req = 1'b1;
        wait_until(base + 560);
        chk("bypass_done", n_done, 1);
        chk("bypass_done_cycle", done_cyc, base + 11);
        chk("bypass_miss", n_miss, 1);
        chk("bypass_hit", n_hit, 0);
        chk("bypass_black", n_black + n_white, 0);
        chk("bypass_busy", n_busy, 0);
`else
        v = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
        run_seq(v);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
